// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with direct select or prescaled auto-scan
module decoder_scan #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ena,
  input  logic           mode,
  input  logic [N-1:0]   n,
  input  logic [N-1:0]   last,
  output logic [2**N-1:0] d,
  output logic [N-1:0]   idx,
  output logic           wrap
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  logic [PW-1:0] pre;
  logic          active;
  logic          tick;
  logic          at_end;
  assign tick   = pre == PW'(DIV - 1);
  assign at_end = idx >= last;
  // wrap covers last lowered below idx mid-scan, not just idx == last
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      idx    <= '0;
      active <= 1'b0;
      pre    <= '0;
      wrap   <= 1'b0;
    end else if (!ena) begin
      active <= 1'b0;
      wrap   <= 1'b0;
    end else if (!mode) begin
      idx    <= n;
      active <= 1'b1;
      pre    <= '0;
      wrap   <= 1'b0;
    end else begin
      active <= 1'b1;
      pre    <= tick ? '0 : pre + 1'b1;
      wrap   <= tick && at_end;
      if (tick) idx <= at_end ? '0 : idx + 1'b1;
    end
  assign d = active ? (2**N)'(1) << idx : '0;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: vector table plus scoreboarded multi-cycle sequences for decoder_scan
module tb_decoder_scan;
  logic       clk, clrn, ena, mode;
  logic [2:0] n, last;
  logic [7:0] d;
  logic [2:0] idx;
  logic       wrap;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       e, m;
    logic [2:0] n, l;
    logic [7:0] d;
    logic [2:0] i;
    logic       w;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] i;
    logic       w;
    string      nm;
  } exp_t;

  vec_t tbl[9];
  exp_t sb[$];

  decoder_scan #(.N(3), .DIV(4)) dut (
    .clk(clk), .clrn(clrn), .ena(ena), .mode(mode),
    .n(n), .last(last), .d(d), .idx(idx), .wrap(wrap)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic m, input logic [2:0] nn, input logic [2:0] ll,
                     input logic [7:0] ed, input logic [2:0] ei, input logic ew, input string nm);
    exp_t x;
    ena = e; mode = m; n = nn; last = ll;
    sb.push_back('{ed, ei, ew, nm});
    @(negedge clk);
    x = sb.pop_front();
    chk({x.nm, ".d"}, 32'(d), 32'(x.d));
    chk({x.nm, ".idx"}, 32'(idx), 32'(x.i));
    chk({x.nm, ".wrap"}, 32'(wrap), 32'(x.w));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 3'(i), 3'd0, 8'(1) << i, 3'(i), 1'b0};
    tbl[8] = '{1'b0, 1'b0, 3'bxxx, 3'd0, 8'h00, 3'd7, 1'b0};
    clrn = 0; ena = 0; mode = 0; n = 0; last = 0;
    #3;
    chk("reset.d", 32'(d), 0);
    chk("reset.idx", 32'(idx), 0);
    chk("reset.wrap", 32'(wrap), 0);
    @(negedge clk);
    clrn = 1;
    foreach (tbl[i]) cyc(tbl[i].e, tbl[i].m, tbl[i].n, tbl[i].l, tbl[i].d, tbl[i].i, tbl[i].w, $sformatf("vec%0d", i));
    // scan 0..5 with 4-cycle steps, 24-cycle period
    cyc(1, 0, 0, 5, 8'h01, 0, 0, "load0");
    for (int k = 1; k <= 24; k++)
      cyc(1, 1, 0, 5, 8'(1) << ((k / 4) % 6), 3'((k / 4) % 6), k == 24, $sformatf("scan5_%0d", k));
    for (int k = 1; k <= 16; k++)
      cyc(1, 1, 0, 5, 8'(1) << (k / 4), 3'(k / 4), 0, $sformatf("pre_lower_%0d", k));
    for (int k = 1; k <= 3; k++) cyc(1, 1, 0, 2, 8'h10, 4, 0, "lowered_hold");
    cyc(1, 1, 0, 2, 8'h01, 0, 1, "lowered_wrap");
    cyc(1, 1, 0, 2, 8'h01, 0, 0, "lowered_after");
    // mode switches: pending prescaler count must be discarded
    cyc(1, 0, 3, 7, 8'h08, 3, 0, "load3");
    cyc(1, 1, 0, 7, 8'h08, 3, 0, "scan3a");
    cyc(1, 1, 0, 7, 8'h08, 3, 0, "scan3b");
    cyc(1, 0, 6, 7, 8'h40, 6, 0, "direct6");
    for (int k = 1; k <= 8; k++)
      cyc(1, 1, 0, 7, k < 4 ? 8'h40 : k < 8 ? 8'h80 : 8'h01, k < 4 ? 3'd6 : k < 8 ? 3'd7 : 3'd0,
          k == 8, $sformatf("rescan_%0d", k));
    // disable mid-count then resume
    cyc(1, 1, 0, 7, 8'h01, 0, 0, "pre_dis1");
    cyc(1, 1, 0, 7, 8'h01, 0, 0, "pre_dis2");
    for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 7, 8'h00, 0, 0, "disabled");
    cyc(1, 1, 0, 7, 8'h01, 0, 0, "resume1");
    cyc(1, 1, 0, 7, 8'h02, 1, 0, "resume2");
    for (int k = 1; k <= 4; k++) cyc(1, 1, 0, 7, k < 4 ? 8'h02 : 8'h04, k < 4 ? 3'd1 : 3'd2, 0, "pre_rst");
    // async reset between edges, held across one edge
    #2 clrn = 0;
    #1;
    chk("arst.d", 32'(d), 0);
    chk("arst.idx", 32'(idx), 0);
    chk("arst.wrap", 32'(wrap), 0);
    #9;
    chk("arst_hold.d", 32'(d), 0);
    chk("arst_hold.idx", 32'(idx), 0);
    #2 clrn = 1;
    for (int k = 1; k <= 4; k++)
      cyc(1, 1, 0, 7, k < 4 ? 8'h01 : 8'h02, k < 4 ? 3'd0 : 3'd1, 0, $sformatf("restart_%0d", k));
    cyc(1, 0, 0, 0, 8'h01, 0, 0, "load0b");
    for (int k = 1; k <= 8; k++)
      cyc(1, 1, 0, 0, 8'h01, 0, k % 4 == 0, $sformatf("last0_%0d", k));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
